mdu_ctrl: RTL and testbench

Multiply/divide sequencer for the EX stage. Owns the HI/LO register pair, launches operations on the shared `mul` and `div` units, and holds the pipeline through `stallreq_for_ex` until a result has been written to HI/LO. Sits beside the ALU in EX. It takes decoded MDU opcodes and EX operands, and returns HI/LO read data for `mfhi`/`mflo`.

---
 rtl/mdu_ctrl_pkg.sv | 54 +++++
 rtl/mdu_ctrl_hilo.sv | 51 +++++
 rtl/mdu_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared constants and types for the EX-stage multiply/divide sequencer.
// Holds the pipeline control encodings (stall/no-stall, divider start and
// ready levels), the stall bus type, the MDU FSM state encoding and the
// multiplier latency limit used to size the wait counter.
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

    // Pipeline stall bus; bit StallExBit is the "EX is not advancing" bit.
    localparam int StallBusW  = 6;
    localparam int StallExBit = 3;
    typedef logic [StallBusW-1:0] StallBus;

    // Stall request levels.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Divider handshake levels.
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Longest multiplier latency the wait counter can represent.
    localparam int MulLatMax = 15;
    localparam int MulCntW   = 4;

    // MDU sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE     = 2'd0,
        MDU_MUL_WAIT = 2'd1,
        MDU_DIV_WAIT = 2'd2,
        MDU_DONE     = 2'd3
    } mdu_state_e;

    // Value loaded into the wait counter at launch. The counter runs down to
    // zero inside MUL_WAIT, so a latency of L needs L-1 as its start value.
    // Out-of-range latencies are clamped so the counter never wraps.
    function automatic logic [MulCntW-1:0] mulCntLoad(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < 1) begin
            clamped = 1;
        end
        if (clamped > MulLatMax) begin
            clamped = MulLatMax;
        end
        return MulCntW'(clamped - 1);
    endfunction

endpackage

// File: rtl/mdu_ctrl_hilo.sv
// ---------------------------------------------------------------------------
// hilo_reg
// The architectural HI/LO register pair.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_we_hi / i_hi_wdata    : single-register write of HI (mthi)
//   i_we_lo / i_lo_wdata    : single-register write of LO (mtlo)
//   i_we_pair / i_pair_wdata: joint 64-bit write {HI, LO} from mul/div
//   o_hi_rdata, o_lo_rdata  : register contents, no bypass
// ---------------------------------------------------------------------------
module hilo_reg
    import mdu_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we_hi,
    input  logic [31:0] i_hi_wdata,
    input  logic        i_we_lo,
    input  logic [31:0] i_lo_wdata,
    input  logic        i_we_pair,
    input  logic [63:0] i_pair_wdata,
    output logic [31:0] o_hi_rdata,
    output logic [31:0] o_lo_rdata
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // The joint write carries a completed mul/div result and wins over the
    // single-register writes; the sequencer never raises both together, so
    // the ordering only matters as a tie-break.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= ZeroWord;
            r_lo <= ZeroWord;
        end else if (i_we_pair) begin
            r_hi <= i_pair_wdata[63:32];
            r_lo <= i_pair_wdata[31:0];
        end else begin
            if (i_we_hi) begin
                r_hi <= i_hi_wdata;
            end
            if (i_we_lo) begin
                r_lo <= i_lo_wdata;
            end
        end
    end

    assign o_hi_rdata = r_hi;
    assign o_lo_rdata = r_lo;

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide sequencer for the EX stage. Owns HI/LO, launches work on
// the external mul and div units and stalls EX until the result is in HI/LO.
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : pipeline stall bus (bit 3 = EX held)
//   annul                    : flush of the EX instruction, aborts the MDU
//   op_mult .. op_mtlo       : one-hot decoded EX opcode (or all zero)
//   src_a, src_b             : EX operands (rs, rt)
//   mul_signed/ina/inb       : registered request to the multiplier
//   mul_result               : multiplier product {hi, lo}
//   div_start/signed/opa/opb : registered request to the divider
//   div_annul                : one-cycle divider abort pulse
//   div_result, div_ready    : divider {remainder, quotient} and ready pulse
//   stallreq_for_ex          : Stop while the MDU holds EX
//   hi_rdata, lo_rdata       : current HI/LO contents
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  StallBus     stall,
    input  logic        annul,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq_for_ex,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    localparam logic [MulCntW-1:0] MulCntStart = mulCntLoad(MUL_LAT);

    mdu_state_e         r_state;
    logic [MulCntW-1:0] r_cnt;
    logic               r_mul_signed;
    logic [31:0]        r_mul_ina;
    logic [31:0]        r_mul_inb;
    logic               r_div_start;
    logic               r_div_signed;
    logic [31:0]        r_div_opa;
    logic [31:0]        r_div_opb;
    logic               r_div_annul;

    mdu_state_e         w_next_state;
    logic [MulCntW-1:0] w_cnt_next;
    logic               w_mul_op;
    logic               w_div_op;
    logic               w_launch_mul;
    logic               w_launch_div;
    logic               w_div_start_next;
    logic               w_div_annul_next;
    logic               w_we_hi;
    logic               w_we_lo;
    logic               w_we_pair;
    logic [63:0]        w_pair_wdata;
    logic               w_stallreq;
    logic               w_ex_held;
    logic               w_unused_stall;

    // Only the EX bit of the stall bus matters here.
    assign w_ex_held      = stall[StallExBit];
    assign w_unused_stall = ^{stall[StallBusW-1:StallExBit+1], stall[StallExBit-1:0]};

    // A divide by zero is never sent to the divider: it leaves HI/LO alone
    // and does not stall, so it does not count as a launchable divide.
    assign w_mul_op = op_mult | op_multu;
    assign w_div_op = (op_div | op_divu) & (src_b != ZeroWord);

    // State register only; everything it depends on is decided below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode. Annul is checked before completion and
    // launch in every state so a flushed instruction never writes HI/LO or
    // starts a unit. The stall request in the wait states does not depend on
    // annul: EX is held until the abort has actually taken effect.
    always_comb begin
        w_next_state     = r_state;
        w_cnt_next       = r_cnt;
        w_launch_mul     = 1'b0;
        w_launch_div     = 1'b0;
        w_div_start_next = DivStop;
        w_div_annul_next = 1'b0;
        w_we_hi          = 1'b0;
        w_we_lo          = 1'b0;
        w_we_pair        = 1'b0;
        w_pair_wdata     = mul_result;
        w_stallreq       = NoStop;

        unique case (r_state)
            MDU_IDLE: begin
                if (!annul) begin
                    if (w_mul_op) begin
                        w_launch_mul = 1'b1;
                        w_cnt_next   = MulCntStart;
                        w_stallreq   = Stop;
                        w_next_state = MDU_MUL_WAIT;
                    end else if (w_div_op) begin
                        w_launch_div     = 1'b1;
                        w_div_start_next = DivStart;
                        w_stallreq       = Stop;
                        w_next_state     = MDU_DIV_WAIT;
                    end else begin
                        w_we_hi = op_mthi;
                        w_we_lo = op_mtlo;
                    end
                end
            end

            MDU_MUL_WAIT: begin
                w_stallreq = Stop;
                if (annul) begin
                    w_next_state = MDU_IDLE;
                end else if (r_cnt == '0) begin
                    w_we_pair    = 1'b1;
                    w_pair_wdata = mul_result;
                    w_next_state = MDU_DONE;
                end else begin
                    w_cnt_next = r_cnt - MulCntW'(1);
                end
            end

            MDU_DIV_WAIT: begin
                w_stallreq = Stop;
                if (annul) begin
                    w_div_annul_next = 1'b1;
                    w_next_state     = MDU_IDLE;
                end else if (div_ready == DivResultReady) begin
                    w_we_pair    = 1'b1;
                    w_pair_wdata = div_result;
                    w_next_state = MDU_DONE;
                end else begin
                    w_div_start_next = DivStart;
                end
            end

            MDU_DONE: begin
                // Parking here while EX is held keeps the still-decoded
                // instruction from launching a second time.
                if (annul || (w_ex_held == NoStop)) begin
                    w_next_state = MDU_IDLE;
                end
            end

            default: begin
                w_next_state = MDU_IDLE;
            end
        endcase
    end

    // Operand and handshake registers. Operands are captured only at launch
    // so the units see stable inputs for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_mul_signed <= 1'b0;
            r_mul_ina    <= ZeroWord;
            r_mul_inb    <= ZeroWord;
            r_div_start  <= DivStop;
            r_div_signed <= 1'b0;
            r_div_opa    <= ZeroWord;
            r_div_opb    <= ZeroWord;
            r_div_annul  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_div_start <= w_div_start_next;
            r_div_annul <= w_div_annul_next;
            if (w_launch_mul) begin
                r_mul_signed <= op_mult;
                r_mul_ina    <= src_a;
                r_mul_inb    <= src_b;
            end
            if (w_launch_div) begin
                r_div_signed <= op_div;
                r_div_opa    <= src_a;
                r_div_opb    <= src_b;
            end
        end
    end

    hilo_reg u_hilo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_we_hi      (w_we_hi),
        .i_hi_wdata   (src_a),
        .i_we_lo      (w_we_lo),
        .i_lo_wdata   (src_a),
        .i_we_pair    (w_we_pair),
        .i_pair_wdata (w_pair_wdata),
        .o_hi_rdata   (hi_rdata),
        .o_lo_rdata   (lo_rdata)
    );

    assign mul_signed      = r_mul_signed;
    assign mul_ina         = r_mul_ina;
    assign mul_inb         = r_mul_inb;
    assign div_start       = r_div_start;
    assign div_signed      = r_div_signed;
    assign div_opa         = r_div_opa;
    assign div_opb         = r_div_opb;
    assign div_annul       = r_div_annul;
    assign stallreq_for_ex = w_stallreq;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Bench for mdu_ctrl with behavioural multiplier and divider units. Expected
// HI/LO values and stall lengths come from plain arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;

    typedef enum int {OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO} opKind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        annul = 1'b0;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0;
    logic        op_divu = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_for_ex;
    logic [31:0] hi_rdata, lo_rdata;

    int checks = 0;
    int errors = 0;

    // Divider environment: ready pulses in the divLat-th cycle of div_start.
    int          divLat = 1;
    int          divCnt = 0;
    logic        forceReady = 1'b0;
    logic [63:0] mulStage = '0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .annul(annul),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div),
        .op_divu(op_divu), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .src_a(src_a), .src_b(src_b),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
        .div_result(div_result), .div_ready(div_ready),
        .stallreq_for_ex(stallreq_for_ex),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    always #5 clk = ~clk;

    // Full 64-bit product of two 32-bit operands.
    function automatic logic [63:0] refMul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // {remainder, quotient}, truncating toward zero for signed operands.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int q, r;
        if (b == 32'h0) begin
            return 64'h0;
        end
        if (sgn) begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Multiplier with MUL_LAT-1 = 1 register stage: the product of operands
    // captured at launch is valid in the last MUL_WAIT cycle.
    always @(posedge clk) mulStage <= refMul(mul_signed, mul_ina, mul_inb);
    assign mul_result = mulStage;

    // Divider cycle counter for the ready pulse.
    always @(posedge clk) begin
        if (div_start && !div_ready) divCnt <= divCnt + 1;
        else                         divCnt <= 0;
    end
    assign div_ready  = (div_start && (divCnt == divLat - 1)) || forceReady;
    assign div_result = refDiv(div_signed, div_opa, div_opb);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a decoded opcode and operands just after a rising edge.
    task automatic applyStimulus(input opKind_e op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op_mult  = (op == OP_MULT);
        op_multu = (op == OP_MULTU);
        op_div   = (op == OP_DIV);
        op_divu  = (op == OP_DIVU);
        op_mthi  = (op == OP_MTHI);
        op_mtlo  = (op == OP_MTLO);
        src_a    = a;
        src_b    = b;
    endtask

    // Issue an op and hold it while EX is stalled; returns at the negedge of
    // the first cycle without a stall request, with the op still decoded.
    task automatic runOp(input opKind_e op, input logic [31:0] a, input logic [31:0] b,
                         output int stallCyc, output int startCyc);
        bit done;
        done     = 1'b0;
        stallCyc = 0;
        startCyc = 0;
        applyStimulus(op, a, b);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (div_start) startCyc++;
            if (stallreq_for_ex) begin
                stallCyc++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("op_terminates", 64'(done), 64'd1);
    endtask

    initial begin
        int          sc, st, pulses;
        opKind_e     op;
        logic [31:0] a, b;
        logic [63:0] res;
        logic [31:0] hiExp, loExp;
        int          expStall;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_hi", 64'(hi_rdata), 64'h0);
        checkOutput("rst_lo", 64'(lo_rdata), 64'h0);
        checkOutput("rst_stallreq", 64'(stallreq_for_ex), 64'h0);
        checkOutput("rst_div_start", 64'(div_start), 64'h0);
        checkOutput("rst_flags", {61'b0, mul_signed, div_signed, div_annul}, 64'h0);
        checkOutput("rst_operands", {mul_ina, div_opb}, 64'h0);

        // mult / multu of 0xFFFFFFFE * 3
        runOp(OP_MULT, 32'hFFFF_FFFE, 32'd3, sc, st);
        checkOutput("mult_stall", 64'(sc), 64'(1 + MUL_LAT));
        checkOutput("mult_hi", 64'(hi_rdata), 64'hFFFF_FFFF);
        checkOutput("mult_lo", 64'(lo_rdata), 64'hFFFF_FFFA);
        checkOutput("mult_signed", 64'(mul_signed), 64'h1);
        applyStimulus(OP_NONE, '0, '0);
        runOp(OP_MULTU, 32'hFFFF_FFFE, 32'd3, sc, st);
        checkOutput("multu_stall", 64'(sc), 64'(1 + MUL_LAT));
        checkOutput("multu_hi", 64'(hi_rdata), 64'h0000_0002);
        checkOutput("multu_lo", 64'(lo_rdata), 64'hFFFF_FFFA);
        checkOutput("multu_signed", 64'(mul_signed), 64'h0);
        applyStimulus(OP_NONE, '0, '0);

        // divu 100/7 with a 33-cycle divider, then signed -7/2
        divLat = 33;
        runOp(OP_DIVU, 32'd100, 32'd7, sc, st);
        checkOutput("divu_stall", 64'(sc), 64'd34);
        checkOutput("divu_start_cycles", 64'(st), 64'd33);
        checkOutput("divu_hi", 64'(hi_rdata), 64'd2);
        checkOutput("divu_lo", 64'(lo_rdata), 64'd14);
        checkOutput("divu_operands", {div_opa, div_opb}, {32'd100, 32'd7});
        applyStimulus(OP_NONE, '0, '0);
        divLat = 4;
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, sc, st);
        checkOutput("div_stall", 64'(sc), 64'd5);
        checkOutput("div_hi", 64'(hi_rdata), 64'hFFFF_FFFF);
        checkOutput("div_lo", 64'(lo_rdata), 64'hFFFF_FFFD);
        checkOutput("div_signed", 64'(div_signed), 64'h1);
        applyStimulus(OP_NONE, '0, '0);

        // Divide by zero leaves HI/LO = 0x11/0x22 and never stalls
        applyStimulus(OP_MTHI, 32'h11, '0);
        applyStimulus(OP_MTLO, 32'h22, '0);
        applyStimulus(OP_DIV, 32'd55, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("div0_stallreq", 64'(stallreq_for_ex), 64'h0);
            checkOutput("div0_start", 64'(div_start), 64'h0);
            @(posedge clk);
            #1;
        end
        applyStimulus(OP_NONE, '0, '0);
        @(negedge clk);
        checkOutput("div0_hilo", {hi_rdata, lo_rdata}, {32'h11, 32'h22});

        // Annul during DIV_WAIT, then a stray ready pulse
        divLat = 33;
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        annul = 1'b1;
        op_divu = 1'b0;
        @(negedge clk);
        checkOutput("annul_stall_held", 64'(stallreq_for_ex), 64'h1);
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        checkOutput("annul_stallreq", 64'(stallreq_for_ex), 64'h0);
        checkOutput("annul_div_start", 64'(div_start), 64'h0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (div_annul) pulses++;
        end
        checkOutput("annul_pulse_count", 64'(pulses), 64'd1);
        @(posedge clk);
        #1 forceReady = 1'b1;
        @(posedge clk);
        #1 forceReady = 1'b0;
        @(negedge clk);
        checkOutput("annul_late_ready_hilo", {hi_rdata, lo_rdata}, {32'h11, 32'h22});

        // mult completing while EX is held: parks in DONE, no relaunch
        stall = 6'b00_1000;
        runOp(OP_MULTU, 32'h0001_0000, 32'h0003_0000, sc, st);
        checkOutput("held_mult_hi", 64'(hi_rdata), 64'h3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("held_stallreq", 64'(stallreq_for_ex), 64'h0);
            checkOutput("held_mul_ina", 64'(mul_ina), 64'h0001_0000);
            checkOutput("held_hilo", {hi_rdata, lo_rdata}, {32'h3, 32'h0});
        end
        @(posedge clk);
        #1 stall = '0;
        @(negedge clk);
        checkOutput("release_stallreq", 64'(stallreq_for_ex), 64'h0);
        applyStimulus(OP_MTHI, 32'h0000_ABCD, '0);
        applyStimulus(OP_NONE, '0, '0);
        @(negedge clk);
        checkOutput("mthi_hi", 64'(hi_rdata), 64'h0000_ABCD);
        checkOutput("mthi_lo_kept", 64'(lo_rdata), 64'h0);

        // Randomized ops against the arithmetic reference
        hiExp = hi_rdata == 32'h0000_ABCD ? 32'h0000_ABCD : 32'h0000_ABCD;
        loExp = 32'h0;
        for (int n = 0; n < 24; n++) begin
            op = opKind_e'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(0, 4) == 0) b = '0;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd9;
            divLat   = $urandom_range(1, 40);
            expStall = 0;
            case (op)
                OP_MULT:  begin res = refMul(1'b1, a, b); {hiExp, loExp} = res; expStall = 1 + MUL_LAT; end
                OP_MULTU: begin res = refMul(1'b0, a, b); {hiExp, loExp} = res; expStall = 1 + MUL_LAT; end
                OP_DIV, OP_DIVU: begin
                    if (b != '0) begin
                        res = refDiv(op == OP_DIV, a, b);
                        {hiExp, loExp} = res;
                        expStall = 1 + divLat;
                    end
                end
                OP_MTHI:  hiExp = a;
                OP_MTLO:  loExp = a;
                default:  ;
            endcase
            runOp(op, a, b, sc, st);
            applyStimulus(OP_NONE, '0, '0);
            @(negedge clk);
            checkOutput($sformatf("rand%0d_stall", n), 64'(sc), 64'(expStall));
            checkOutput($sformatf("rand%0d_hilo", n), {hi_rdata, lo_rdata}, {hiExp, loExp});
        end

        // Reset in the middle of MUL_WAIT
        applyStimulus(OP_MULT, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        op_mult = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_hilo", {hi_rdata, lo_rdata}, 64'h0);
        checkOutput("midrst_stallreq", 64'(stallreq_for_ex), 64'h0);
        checkOutput("midrst_div_annul", 64'(div_annul), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_no_late_write", {hi_rdata, lo_rdata}, 64'h0);

        $display("[TB] directed and random sequences complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
